zmips_regfile_sb: RTL
=====================

Name: zmips_regfile_sb

Overview:
Parametrised successor to the zmips 32x32 register file. It provides NRD read ports, one write port, a saved-PC register and a per-register pending-write scoreboard, so the decode stage can detect load-use and long-latency hazards. It sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear).

Parameters:
DW, 32, data width of registers and PC
AW, 5, register address width; address space is 2**AW
NREGS, 30, number of general registers (addresses 0..NREGS-1); must be <= 2**AW-2
NRD, 2, number of read ports

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NRD*AW  read addresses; port i = bits [i*AW +: AW]
rd_data  out  NRD*DW  read data; port i = bits [i*DW +: DW]
rd_busy  out  NRD  1 = register read on port i has a pending write
pc_val  in  DW  live PC from fetch
pc_wr  in  1  capture pc_val into saved-PC register
wr  in  1  write enable
wr_addr  in  AW  write address
wr_data  in  DW  write data
sb_set  in  1  mark sb_addr as pending-write
sb_addr  in  AW  register to mark
sb_any  out  1  OR of all busy bits

Behaviour:
- Address map: 0..NREGS-1 = general regs; 2**AW-2 = PC_LIVE (reads pc_val combinationally); 2**AW-1 = PC_SAVED (reads saved-PC register); any other address reads 0.
- Reads: combinational, 0 latency, all NRD ports independent; same address on several ports is legal.
- Write: on clk rising edge when wr=1 and wr_addr<NREGS, regfile[wr_addr] <= wr_data. Writes to PC_LIVE, PC_SAVED or unmapped addresses are ignored (no state change, no busy clear).
- Without bypass, written data is visible on rd_data from the cycle after the edge.
- Saved PC: pc_wr=1 -> pc_reg <= pc_val at the edge; independent of wr, so both may occur in the same cycle.
- Scoreboard: one busy bit per general reg.
  - sb_set=1 and sb_addr<NREGS sets busy[sb_addr].
  - wr=1 and wr_addr<NREGS clears busy[wr_addr].
  - Same address set and cleared in the same cycle: set wins (newer producer issuing as older retires); bit stays 1.
  - Different addresses: both take effect.
  - sb_set to an unmapped or PC address is ignored.
- rd_busy[i] = busy[rd_addr[i]] for general regs; 0 for PC and unmapped addresses. Reflects registered state only (no same-cycle set/clear lookahead).
- sb_any = |busy, from registered state.
- Reset (asynchronous, rst_n=0): all general regs, pc_reg and busy bits go to 0 immediately.
  - Consequences: rd_data reads 0 for general regs and PC_SAVED; rd_data reads pc_val for PC_LIVE; rd_busy=0; sb_any=0.
  - Writes, sets and pc_wr are ignored while rst_n=0.
  - Reset asserted mid-operation discards pending busy bits with no further action.
  - Release is synchronised externally by the design; the block takes no action of its own on release.

Optional Feature:
Macro ZMIPS_RF_BYPASS_EN.
- Defined: write-through forwarding. If wr=1, wr_addr<NREGS and rd_addr[i]==wr_addr, then rd_data[i]=wr_data and rd_busy[i]=0 in the same cycle, unless sb_set targets the same address that cycle (busy stays reported from registered state = 1 only if it was already set). Adds a comparator per read port.
- Undefined: no forwarding; same-cycle reads of a register being written return the old value and the old busy bit.

Test Plan:
- Reset: assert rst_n=0 mid-run with regs and busy bits nonzero -> all rd_data=0 (PC_LIVE = pc_val), rd_busy=0, sb_any=0 with no clock edge.
- Write/read: write 0xDEADBEEF to r5, read r5 on ports 0 and 1 next cycle -> both 0xDEADBEEF; write to addr 30 and 31 -> no general reg changes.
- PC: pc_val=0x00400010, pc_wr=1 -> next cycle addr 31 reads 0x00400010; change pc_val to 0x00400014 -> addr 30 reads 0x00400014, addr 31 unchanged.
- Scoreboard: sb_set r7 -> rd_busy=1 on r7, sb_any=1; wr r7 -> busy clears next cycle; sb_set r7 and wr r7 in the same cycle -> busy remains 1.
- Unmapped (NREGS=16): write r20 and sb_set r20 -> reads 0, rd_busy=0, sb_any unchanged.
- Bypass (with macro defined): wr r3=0x12345678 while reading r3 in the same cycle -> rd_data=0x12345678; without the macro -> previous value.

Source files
------------

// File: rtl/zmips_regfile_sb.sv
// zmips_regfile_sb
// ----------------
// This is a parametrised zmips register file with a per-register
// pending-write scoreboard. Decode reads operands here and marks
// destination registers busy. Writeback writes results and clears the busy
// bits, so decode can stall on load-use and long-latency hazards.
//
// Address map (AW-bit addresses):
//   0 .. NREGS-1  general registers
//   2**AW-2       PC_LIVE  : reads i_pc_val combinationally
//   2**AW-1       PC_SAVED : reads the saved-PC register
//   anything else reads 0 and is never busy
//
// Optional feature macro: ZMIPS_RF_BYPASS_EN
//   When it is defined, a write in the current cycle is forwarded to any
//   read port that addresses the same general register. That port's busy
//   flag is also reported as 0, unless the same register is being re-marked
//   busy in that cycle.
//   When it is undefined, reads see only registered state.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   i_rd_addr    NRD packed read addresses, port p = [p*AW +: AW]
//   o_rd_data    NRD packed read data,      port p = [p*DW +: DW]
//   o_rd_busy    per-port pending-write flag
//   i_pc_val     live PC from fetch
//   i_pc_wr      capture i_pc_val into the saved-PC register
//   i_wr         write enable
//   i_wr_addr    write address
//   i_wr_data    write data
//   i_sb_set     mark i_sb_addr as pending-write
//   i_sb_addr    register to mark
//   o_sb_any     OR of all busy bits
module zmips_regfile_sb #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NREGS = 30,
  parameter int NRD   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] i_rd_addr,
  output logic [NRD*DW-1:0] o_rd_data,
  output logic [NRD-1:0]    o_rd_busy,
  input  logic [DW-1:0]     i_pc_val,
  input  logic              i_pc_wr,
  input  logic              i_wr,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DW-1:0]     i_wr_data,
  input  logic              i_sb_set,
  input  logic [AW-1:0]     i_sb_addr,
  output logic              o_sb_any
);

  localparam logic [AW-1:0] PC_SAVED = {AW{1'b1}};
  localparam logic [AW-1:0] PC_LIVE  = {{(AW-1){1'b1}}, 1'b0};

  logic [DW-1:0]    r_regs [NREGS];
  logic [DW-1:0]    r_pc;
  logic [NREGS-1:0] r_busy;

  logic [AW-1:0]    w_rd_addr [NRD];

  genvar gp;
  generate
    for (gp = 0; gp < NRD; gp++) begin : g_rd_addr
      assign w_rd_addr[gp] = i_rd_addr[gp*AW +: AW];
    end
  endgenerate

  // Register array and saved PC.
  // The address decode is done by comparing against each register index.
  // As a result, PC and unmapped write addresses match nothing and are
  // dropped naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_pc <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i_wr && (i_wr_addr == AW'(i))) begin
          r_regs[i] <= i_wr_data;
        end
      end
      if (i_pc_wr) begin
        r_pc <= i_pc_val;
      end
    end
  end

  // Scoreboard. A set takes priority over a clear on the same register.
  // In that case, a newer producer issues while the older one retires, so
  // the register must stay pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i_sb_set && (i_sb_addr == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (i_wr && (i_wr_addr == AW'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign o_sb_any = |r_busy;

`ifdef ZMIPS_RF_BYPASS_EN
  logic [AW:0] w_nregs;
  logic        w_wr_hit;

  assign w_nregs  = (AW+1)'(NREGS);
  assign w_wr_hit = i_wr && ({1'b0, i_wr_addr} < w_nregs);
`endif

  // Read ports.
  // Each port is an independent combinational mux over the general
  // registers, the live PC and the saved PC. Unmapped addresses fall
  // through to the zero default.
  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_rd_addr[p] == AW'(i)) begin
          o_rd_data[p*DW +: DW] = r_regs[i];
          o_rd_busy[p]          = r_busy[i];
        end
      end
      if (w_rd_addr[p] == PC_LIVE) begin
        o_rd_data[p*DW +: DW] = i_pc_val;
      end
      if (w_rd_addr[p] == PC_SAVED) begin
        o_rd_data[p*DW +: DW] = r_pc;
      end
`ifdef ZMIPS_RF_BYPASS_EN
      if (w_wr_hit && (w_rd_addr[p] == i_wr_addr)) begin
        o_rd_data[p*DW +: DW] = i_wr_data;
        if (!(i_sb_set && (i_sb_addr == i_wr_addr))) begin
          o_rd_busy[p] = 1'b0;
        end
      end
`endif
    end
  end

endmodule
